dmem_logger: RTL and testbench
==============================

# dmem_logger

Word-addressed data memory for the MIPS core with an integrated write-log FIFO. It sits on the processor's data-memory bus (`memwrite`, `dataadr`, `writedata`), serves combinational reads and performs clocked writes. Every write cycle is recorded as an (address, data) entry. A checker or debug port drains the entries over a valid/ready interface, so self-checking benches and on-chip monitors can consume the processor's store stream in order.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit memory words. Power of two, ≥ 2.
- `LOG_DEPTH`, default 8: write-log FIFO entries. Power of two, ≥ 2.
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset for all control state.
- `memwrite` in 1: store strobe. Each high cycle is one write.
- `dataadr` in 32: byte address, used for both read and write.
- `writedata` in 32: store data.
- `readdata` out 32: combinational read data.
- `log_valid` out 1: log head entry is available.
- `log_ready` in 1: consumer accepts the head entry.
- `log_addr` out 32: head entry address, exactly as presented on `dataadr`.
- `log_data` out 32: head entry data.
- `log_count` out $clog2(LOG_DEPTH+1): number of occupied log entries.
- `log_overflow` out 1: sticky; set when a write could not be logged.
- `addr_err` out 1: sticky; set on a misaligned or out-of-range write.

## Operation
- Word index is `dataadr[AW+1:2]`, with AW = $clog2(DEPTH_WORDS).
- An address is in range when `dataadr[31:2] < DEPTH_WORDS`.
- An address is aligned when `dataadr[1:0] == 0`.
- Write: on a rising edge with `memwrite`=1 and the address both aligned and in range, `mem[index] <= writedata`.
- Misaligned or out-of-range write: memory is unchanged and `addr_err` is set.
- Read: `readdata = mem[index]` when in range, otherwise 0. `dataadr[1:0]` is ignored for reads.
- Memory contents are not cleared by reset. A word reads X until it is first written.
- Log push: every cycle with `memwrite`=1 pushes {`dataadr`, `writedata`}, including rejected writes, so the consumer sees the raw store stream.
- Log pop: occurs on a rising edge with `log_valid` && `log_ready`.
- The log is first-word-fall-through: `log_addr` and `log_data` always show the oldest entry whenever `log_valid`=1.
- `log_valid = (log_count != 0)`. Head outputs are don't-care when `log_valid`=0.
- Full, push only: the entry is dropped, `log_overflow` is set, and contents and count are unchanged.
- Full, push and pop in the same cycle: the pop frees a slot and the push is accepted. Count stays at LOG_DEPTH and `log_overflow` is not set.
- Empty, push and pop in the same cycle: no pop occurs because `log_valid`=0. The push is accepted and count becomes 1.
- Pointers wrap modulo LOG_DEPTH. Count is maintained separately so that full and empty are unambiguous.
- Sticky flags clear only on reset.

## Timing
- Reset (`reset`=0, asynchronous):
  - `log_count`=0, both pointers=0, `log_valid`=0.
  - `log_overflow`=0, `addr_err`=0.
  - Writes and pushes are suppressed while `reset`=0.
- `readdata` settles combinationally from `dataadr`. A write is visible on `readdata` starting in the cycle after the write edge.
- Push to empty log: `log_valid` rises in the cycle after the push edge (1-cycle latency).
- Pop: the next entry appears on the head outputs in the same cycle in which `log_count` decrements.
- Reset asserted mid-operation: log entries are discarded immediately. Memory words written before reset are retained.
- `memwrite` held high for k cycles produces k writes and k log entries.

## Test plan
- Reset, then stores 0x7→0x50, 0x7→0x54, 0x4e→0x58 with `log_ready`=0:
  - `log_count`=3.
  - Draining yields (0x50,0x7), (0x54,0x7), (0x58,0x4e) in order.
  - `readdata` at 0x58 is 0x4e.
- Nine consecutive stores with LOG_DEPTH=8 and `log_ready`=0: `log_count`=8, `log_overflow`=1, and the head is still the first store.
- Log full, then a store with `log_ready`=1 in the same cycle: count stays 8, `log_overflow` stays 0, and the last entry drained is the new store.
- Misaligned store 0x11→0x5E and out-of-range store 0x28→0x400 (DEPTH_WORDS=64):
  - `addr_err`=1.
  - Memory words 0x5C and 0x00 are unchanged.
  - Both stores appear in the log.
- Three stores pushed, `reset` pulsed low mid-cycle:
  - `log_valid`=0, `log_count`=0 and the flags are 0 immediately, without waiting for a clock edge.
  - After release, `readdata` at a previously written address still returns its data.
- Store then load at the same address on the next cycle: `readdata` equals the stored value. An out-of-range load returns 0.

Source files
------------

// File: rtl/dmem_logger.sv
// dmem_logger: word-addressed data memory with a FWFT write-log FIFO.
// Ports:
//   clk, reset (async, active-low)
//   memwrite, dataadr, writedata: store bus in; readdata: comb read out
//   log_valid/log_ready/log_addr/log_data: head of the store log
//   log_count: occupancy
//   log_overflow, addr_err: sticky error flags
module dmem_logger #(
  parameter int DEPTH_WORDS = 64,
  parameter int LOG_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             memwrite,
  input  logic [31:0]                      dataadr,
  input  logic [31:0]                      writedata,
  output logic [31:0]                      readdata,
  output logic                             log_valid,
  input  logic                             log_ready,
  output logic [31:0]                      log_addr,
  output logic [31:0]                      log_data,
  output logic [$clog2(LOG_DEPTH+1)-1:0]   log_count,
  output logic                             log_overflow,
  output logic                             addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LOG_DEPTH);
  localparam int CW = $clog2(LOG_DEPTH+1);

  logic [31:0]   mem    [DEPTH_WORDS];
  logic [31:0]   q_addr [LOG_DEPTH];
  logic [31:0]   q_data [LOG_DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          wr_ok;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign idx      = dataadr[AW+1:2];
  // power-of-two depth: in range iff all bits above the index are zero
  assign in_range = (dataadr[31:AW+2] == '0);
  assign aligned  = (dataadr[1:0] == 2'b00);
  assign wr_ok    = memwrite && aligned && in_range;

  assign readdata = in_range ? mem[idx] : 32'h0;

  assign log_valid = (log_count != '0);
  assign full      = (log_count == CW'(LOG_DEPTH));
  assign pop       = log_valid && log_ready;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok   = memwrite && (!full || pop);

  assign log_addr = q_addr[rd_ptr];
  assign log_data = q_data[rd_ptr];

  // memory and log storage are not reset; only control state is
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_count    <= '0;
      log_overflow <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      if (wr_ok)
        mem[idx] <= writedata;
      if (push_ok) begin
        q_addr[wr_ptr] <= dataadr;
        q_data[wr_ptr] <= writedata;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push_ok && !pop: log_count <= log_count + 1'b1;
        pop && !push_ok: log_count <= log_count - 1'b1;
        default: ;
      endcase
      if (memwrite && !push_ok)
        log_overflow <= 1'b1;
      if (memwrite && !(aligned && in_range))
        addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_logger.sv
// tb_dmem_logger: scoreboard bench for dmem_logger.
// Stimulus pushes expected log entries; a negedge monitor checks pops.
module tb_dmem_logger;

  localparam int DW = 64;
  localparam int LD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        log_ready = 1'b0;
  logic [31:0] readdata;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic [3:0]  log_count;
  logic        log_overflow;
  logic        addr_err;

  dmem_logger #(.DEPTH_WORDS(DW), .LOG_DEPTH(LD)) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .dataadr(dataadr),
    .writedata(writedata),
    .readdata(readdata),
    .log_valid(log_valid),
    .log_ready(log_ready),
    .log_addr(log_addr),
    .log_data(log_data),
    .log_count(log_count),
    .log_overflow(log_overflow),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        sb[$];
  ent_t        mon_e;
  logic [31:0] m_mem [DW];
  bit          m_known [DW];
  bit          m_ovf = 1'b0;
  bit          m_aerr = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit ok_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DW));
  endfunction

  // monitor: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    if (reset && log_valid && log_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL log_extra: got %h/%h expected none",
                 log_addr, log_data);
      end else begin
        mon_e = sb.pop_front();
        chk("log_addr", log_addr, mon_e.a);
        chk("log_data", log_data, mon_e.d);
      end
    end
  end

  // drive one cycle; the model reflects the state after the edge
  task automatic cyc(input bit mw, input logic [31:0] a,
                     input logic [31:0] d, input bit rdy);
    bit popw;
    bit fullm;
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    log_ready = rdy;
    popw  = (sb.size() > 0) && rdy;
    fullm = (sb.size() >= LD);
    if (mw) begin
      if (!fullm || popw) sb.push_back('{a, d});
      else m_ovf = 1'b1;
      if (ok_addr(a)) begin
        m_mem[a[7:2]]   = d;
        m_known[a[7:2]] = 1'b1;
      end else begin
        m_aerr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a);
    memwrite = 1'b0;
    dataadr  = a;
    #1;
    if (a[31:2] >= 30'(DW)) chk(nm, readdata, 32'h0);
    else if (m_known[a[7:2]]) chk(nm, readdata, m_mem[a[7:2]]);
  endtask

  task automatic drain();
    repeat (LD + 2) cyc(1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("drain_cnt", 32'(log_count), 32'h0);
  endtask

  task automatic chk_cnt(input string nm);
    chk(nm, 32'(log_count), 32'(sb.size()));
    chk({nm, "_v"}, 32'(log_valid), 32'(sb.size() != 0));
  endtask

  logic [31:0] ra;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < DW; i++) m_known[i] = 1'b0;
    #2;
    chk("rst_cnt", 32'(log_count), 32'h0);
    chk("rst_valid", 32'(log_valid), 32'h0);
    chk("rst_ovf", 32'(log_overflow), 32'h0);
    chk("rst_aerr", 32'(addr_err), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // basic store stream
    cyc(1'b1, 32'h50, 32'h7, 1'b0);
    cyc(1'b1, 32'h54, 32'h7, 1'b0);
    cyc(1'b1, 32'h58, 32'h4e, 1'b0);
    chk("t1_cnt", 32'(log_count), 32'h3);
    rd_chk("t1_rd58", 32'h58);
    chk("t1_rd58_k", readdata, 32'h4e);
    drain();

    // full with simultaneous pop: push accepted, no overflow
    for (int i = 0; i < LD; i++)
      cyc(1'b1, 32'(4 * i), $urandom(), 1'b0);
    chk("t3_full", 32'(log_count), 32'h8);
    cyc(1'b1, 32'h80, 32'hcafe0001, 1'b1);
    chk("t3_cnt", 32'(log_count), 32'h8);
    chk("t3_ovf", 32'(log_overflow), 32'h0);
    drain();

    // overflow: ninth store dropped
    for (int i = 0; i < LD + 1; i++)
      cyc(1'b1, 32'(64 + 4 * i), $urandom(), 1'b0);
    chk("t2_cnt", 32'(log_count), 32'h8);
    chk("t2_ovf", 32'(log_overflow), 32'h1);
    chk("t2_head", log_addr, 32'h40);
    drain();

    // bad addresses
    cyc(1'b1, 32'h5c, 32'haaaa5555, 1'b0);
    cyc(1'b1, 32'h0, 32'h12345678, 1'b0);
    chk("t4_aerr0", 32'(addr_err), 32'h0);
    cyc(1'b1, 32'h5e, 32'h11, 1'b0);
    cyc(1'b1, 32'h400, 32'h28, 1'b0);
    chk("t4_aerr", 32'(addr_err), 32'h1);
    chk("t4_cnt", 32'(log_count), 32'h4);
    rd_chk("t4_rd5c", 32'h5c);
    chk("t4_rd5c_k", readdata, 32'haaaa5555);
    rd_chk("t4_rd00", 32'h0);
    drain();

    // async reset mid-cycle
    cyc(1'b1, 32'h10, 32'h1, 1'b0);
    cyc(1'b1, 32'h14, 32'h2, 1'b0);
    cyc(1'b1, 32'h18, 32'h3, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst2_valid", 32'(log_valid), 32'h0);
    chk("rst2_cnt", 32'(log_count), 32'h0);
    chk("rst2_ovf", 32'(log_overflow), 32'h0);
    chk("rst2_aerr", 32'(addr_err), 32'h0);
    sb.delete();
    m_ovf  = 1'b0;
    m_aerr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd_chk("rst2_rd14", 32'h14);
    chk("rst2_rd14_k", readdata, 32'h2);

    // store then load, out-of-range load
    cyc(1'b1, 32'h20, 32'hdeadbeef, 1'b0);
    rd_chk("sl_rd20", 32'h20);
    rd_chk("sl_oor", 32'h1000);
    drain();

    // randomized traffic
    repeat (400) begin
      ra = 32'($urandom_range(0, DW - 1)) << 2;
      case ($urandom_range(0, 9))
        8: ra = ra | 32'($urandom_range(1, 3));
        9: ra = 32'h100 + ($urandom() & 32'hfffc);
        default: ;
      endcase
      rd = $urandom();
      cyc(1'($urandom_range(0, 1)), ra, rd,
          $urandom_range(0, 3) != 0);
      chk_cnt("rnd_cnt");
      if ($urandom_range(0, 3) == 0)
        rd_chk("rnd_rd", 32'($urandom_range(0, DW + 7)) << 2);
    end
    chk("rnd_ovf", 32'(log_overflow), 32'(m_ovf));
    chk("rnd_aerr", 32'(addr_err), 32'(m_aerr));
    drain();
    chk("end_sb", 32'(sb.size()), 32'h0);
    chk("end_valid", 32'(log_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
